// File: rtl/cpu_pkg.sv
// Shared opcode / ALU-op encodings, sequencer state type and the strobe bundle
// used between the control sequencer and its decoder.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED, S_FAULT
  } state_e;

  typedef struct packed {
    logic        pc_out;
    logic        mar_in;
    logic        inc_pc;
    logic        pc_in;
    logic        read;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        z_low_out;
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic [3:0]  alu_op;
  } ctl_t;

  function automatic logic [15:0] onehot16(logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

  function automatic ctl_t ctl_t0();
    ctl_t c = '0;
    c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
    c.alu_op = ALU_ADD;
    return c;
  endfunction

  // PC write-back only happens on the first fetch-wait cycle; read is held throughout
  function automatic ctl_t ctl_t1(logic first);
    ctl_t c = '0;
    c.read = 1'b1; c.mdr_in = 1'b1; c.pc_in = first; c.z_low_out = first;
    return c;
  endfunction

  function automatic ctl_t ctl_t2();
    ctl_t c = '0;
    c.mdr_out = 1'b1; c.ir_in = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_t4(logic [15:0] rc, logic [3:0] op);
    ctl_t c = '0;
    c.gpr_out = rc; c.alu_op = op; c.z_in = 1'b1;
    return c;
  endfunction

  function automatic ctl_t ctl_t5(logic [15:0] ra, logic [3:0] op);
    ctl_t c = '0;
    c.z_low_out = 1'b1; c.gpr_in = ra; c.alu_op = op;
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath control bundle: strobes out, IR contents and memory ready back.
interface control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
  logic        y_in, z_in, z_low_out;
  logic [15:0] gpr_in, gpr_out;
  logic [3:0]  alu_op;

  modport master (
    input  ir, mem_ready,
    output pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, gpr_in, gpr_out, alu_op
  );

  modport slave (
    output ir, mem_ready,
    input  pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, gpr_in, gpr_out, alu_op
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decode: class flags, ALU op and one-hot register selects.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] ir,
  output logic        is_binary,
  output logic        is_unary,
  output logic        is_nop,
  output logic        is_halt,
  output logic        is_illegal,
  output logic [3:0]  alu_op,
  output logic [15:0] ra_sel,
  output logic [15:0] rb_sel,
  output logic [15:0] rc_sel
);
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  assign ra_sel    = onehot16(ir[26:23]);
  assign rb_sel    = onehot16(ir[22:19]);
  assign rc_sel    = onehot16(ir[18:15]);
  assign unused_ir = ^ir[14:0];

  always_comb begin
    is_binary  = 1'b0;
    is_unary   = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_AND;
    case (opcode)
      OP_ADD:  begin is_binary = 1'b1; alu_op = ALU_ADD; end
      OP_SUB:  begin is_binary = 1'b1; alu_op = ALU_SUB; end
      OP_SHR:  begin is_binary = 1'b1; alu_op = ALU_SHR; end
      OP_SHL:  begin is_binary = 1'b1; alu_op = ALU_SHL; end
      OP_ROR:  begin is_binary = 1'b1; alu_op = ALU_ROR; end
      OP_ROL:  begin is_binary = 1'b1; alu_op = ALU_ROL; end
      OP_AND:  begin is_binary = 1'b1; alu_op = ALU_AND; end
      OP_OR:   begin is_binary = 1'b1; alu_op = ALU_OR;  end
      OP_NEG:  begin is_unary  = 1'b1; alu_op = ALU_NEG; end
      OP_NOT:  begin is_unary  = 1'b1; alu_op = ALU_NOT; end
      OP_NOP:  is_nop  = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit driving the datapath strobes.
// Strobes are registered one state ahead; only the decode cycle is formed from the live IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int FETCH_TIMEOUT  = 15,
  parameter bit START_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  control_sequencer_if.master bus,
  output logic                run,
  output logic                illegal
);
  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e      state;
  ctl_t        ctl_q, dec_ctl, ctl;
  logic [7:0]  wait_cnt;
  logic        armed;
  logic        run_q;
  logic [15:0] ra_q;
  logic [3:0]  alu_q;

  logic        is_binary, is_unary, is_nop, is_halt, is_illegal;
  logic [3:0]  dec_alu;
  logic [15:0] ra_sel, rb_sel, rc_sel;
  logic        unused_dec;

  instr_decoder u_dec (
    .ir         (bus.ir),
    .is_binary  (is_binary),
    .is_unary   (is_unary),
    .is_nop     (is_nop),
    .is_halt    (is_halt),
    .is_illegal (is_illegal),
    .alu_op     (dec_alu),
    .ra_sel     (ra_sel),
    .rb_sel     (rb_sel),
    .rc_sel     (rc_sel)
  );

  assign unused_dec = is_nop;

  // IR is only loaded at the end of T2, so T3 strobes cannot be precomputed
  always_comb begin
    dec_ctl = '0;
    if (is_binary) begin
      dec_ctl.gpr_out = rb_sel;
      dec_ctl.y_in    = 1'b1;
    end else if (is_unary) begin
      dec_ctl.gpr_out = rb_sel;
      dec_ctl.alu_op  = dec_alu;
      dec_ctl.z_in    = 1'b1;
    end
  end

  assign ctl     = (state == S_T3) ? dec_ctl : ctl_q;
  assign illegal = (state == S_T3) && is_illegal;
  assign run     = run_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= START_ON_RESET ? S_T0 : S_IDLE;
      ctl_q    <= '0;
      run_q    <= START_ON_RESET;
      armed    <= 1'b0;
      wait_cnt <= '0;
      ra_q     <= '0;
      alu_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_T0;
          ctl_q <= ctl_t0();
          run_q <= 1'b1;
          armed <= 1'b1;
        end
        // the T0 entered straight from reset has quiet outputs, so hold one more cycle
        S_T0: if (!armed) begin
          ctl_q <= ctl_t0();
          armed <= 1'b1;
        end else begin
          state    <= S_T1;
          ctl_q    <= ctl_t1(1'b1);
          wait_cnt <= '0;
        end
        S_T1: if (bus.mem_ready) begin
          state <= S_T2;
          ctl_q <= ctl_t2();
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state <= S_FAULT;
          ctl_q <= '0;
          run_q <= 1'b0;
        end else begin
          ctl_q    <= ctl_t1(1'b0);
          wait_cnt <= wait_cnt + 8'd1;
        end
        S_T2: begin
          state <= S_T3;
          ctl_q <= '0;
        end
        S_T3: begin
          ra_q  <= ra_sel;
          alu_q <= dec_alu;
          if (is_binary) begin
            state <= S_T4;
            ctl_q <= ctl_t4(rc_sel, dec_alu);
          end else if (is_unary) begin
            state <= S_T5;
            ctl_q <= ctl_t5(ra_sel, dec_alu);
          end else if (is_halt) begin
            state <= S_HALTED;
            ctl_q <= '0;
            run_q <= 1'b0;
          end else begin
            state <= S_T0;
            ctl_q <= ctl_t0();
          end
        end
        S_T4: begin
          state <= S_T5;
          ctl_q <= ctl_t5(ra_q, alu_q);
        end
        S_T5: begin
          state <= S_T0;
          ctl_q <= ctl_t0();
        end
        default: begin
          ctl_q <= '0;
          run_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out    = ctl.pc_out;
  assign bus.mar_in    = ctl.mar_in;
  assign bus.inc_pc    = ctl.inc_pc;
  assign bus.pc_in     = ctl.pc_in;
  assign bus.read      = ctl.read;
  assign bus.mdr_in    = ctl.mdr_in;
  assign bus.mdr_out   = ctl.mdr_out;
  assign bus.ir_in     = ctl.ir_in;
  assign bus.y_in      = ctl.y_in;
  assign bus.z_in      = ctl.z_in;
  assign bus.z_low_out = ctl.z_low_out;
  assign bus.gpr_in    = ctl.gpr_in;
  assign bus.gpr_out   = ctl.gpr_out;
  assign bus.alu_op    = ctl.alu_op;
endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-accurate bench: expected strobe traces are built per instruction from the
// fetch/decode/execute rules and compared against the sequencer every cycle.
`timescale 1ns/1ps
module tb_control_sequencer;
  localparam int FT = 15;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, pc_in, read, mdr_in, mdr_out, ir_in;
    logic        y_in, z_in, z_low_out;
    logic [15:0] gpr_in, gpr_out;
    logic [3:0]  alu_op;
    logic        run, illegal;
  } obs_t;

  logic clk = 1'b0;
  logic reset, start, reset2, start2;
  logic run, illegal, run2, illegal2;
  int   vectors = 0;
  int   miscompares = 0;

  control_sequencer_if bus();
  control_sequencer_if bus2();

  control_sequencer #(.FETCH_TIMEOUT(FT), .START_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus), .run(run), .illegal(illegal)
  );
  control_sequencer #(.FETCH_TIMEOUT(FT), .START_ON_RESET(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .bus(bus2), .run(run2), .illegal(illegal2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic obs_t obs1();
    return {bus.pc_out, bus.mar_in, bus.inc_pc, bus.pc_in, bus.read, bus.mdr_in, bus.mdr_out,
            bus.ir_in, bus.y_in, bus.z_in, bus.z_low_out, bus.gpr_in, bus.gpr_out, bus.alu_op,
            run, illegal};
  endfunction

  function automatic obs_t obs2();
    return {bus2.pc_out, bus2.mar_in, bus2.inc_pc, bus2.pc_in, bus2.read, bus2.mdr_in,
            bus2.mdr_out, bus2.ir_in, bus2.y_in, bus2.z_in, bus2.z_low_out, bus2.gpr_in,
            bus2.gpr_out, bus2.alu_op, run2, illegal2};
  endfunction

  function automatic int bus_drivers();
    return int'(bus.pc_out) + int'(bus.mdr_out) + int'(bus.z_low_out) + $countones(bus.gpr_out);
  endfunction

  // kind: 0 binary, 1 unary, 2 nop, 3 halt, 4 undefined
  task automatic classify(input logic [4:0] op, output int kind, output logic [3:0] alu);
    kind = 0;
    alu  = 4'b0000;
    case (op)
      5'b00011: alu = 4'b0010;
      5'b00100: alu = 4'b0011;
      5'b00101: alu = 4'b0100;
      5'b00110: alu = 4'b0101;
      5'b00111: alu = 4'b0110;
      5'b01000: alu = 4'b0111;
      5'b01001: alu = 4'b0000;
      5'b01010: alu = 4'b0001;
      5'b10000: begin kind = 1; alu = 4'b1010; end
      5'b10001: begin kind = 1; alu = 4'b1011; end
      5'b11010: kind = 2;
      5'b11011: kind = 3;
      default:  kind = 4;
    endcase
  endtask

  task automatic cyc(input logic rst, input logic mr, input logic [31:0] iv,
                     input obs_t exp, input string tag);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = mr;
    bus.ir        = iv;
    @(negedge clk);
    chk(tag, 64'(obs1()), 64'(exp));
    chk("bus_excl", 64'(bus_drivers() > 1), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    obs_t e;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    e = '0;
    e.run = 1'b1;
    chk({tag, ":reset"}, 64'(obs1()), 64'(e));
  endtask

  // lat = number of mem_ready-low T1 cycles before ready; lat >= FT means never ready
  task automatic exec_instr(input logic [31:0] iv, input int lat, input bit rst_t4,
                            input string name);
    obs_t        e;
    int          kind;
    logic [3:0]  alu;
    logic [15:0] ra, rb, rc;
    classify(iv[31:27], kind, alu);
    ra = 16'(1) << iv[26:23];
    rb = 16'(1) << iv[22:19];
    rc = 16'(1) << iv[18:15];

    e = '0; e.run = 1'b1;
    e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1; e.alu_op = 4'b0010;
    cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, e, {name, ":T0"});

    for (int k = 0; k < FT; k++) begin
      e = '0; e.run = 1'b1; e.read = 1'b1; e.mdr_in = 1'b1;
      if (k == 0) begin e.pc_in = 1'b1; e.z_low_out = 1'b1; end
      cyc(1'b0, 1'(k == lat), $urandom, e, {name, ":T1"});
      if (k == lat) break;
    end

    if (lat >= FT) begin
      e = '0;
      for (int k = 0; k < 20; k++)
        cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, e, {name, ":FAULT"});
      return;
    end

    e = '0; e.run = 1'b1; e.mdr_out = 1'b1; e.ir_in = 1'b1;
    cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, e, {name, ":T2"});

    e = '0; e.run = 1'b1;
    case (kind)
      0: begin e.gpr_out = rb; e.y_in = 1'b1; end
      1: begin e.gpr_out = rb; e.alu_op = alu; e.z_in = 1'b1; end
      4: e.illegal = 1'b1;
      default: ;
    endcase
    cyc(1'b0, 1'($urandom_range(0, 1)), iv, e, {name, ":T3"});

    if (kind == 3) begin
      e = '0;
      for (int k = 0; k < 10; k++)
        cyc(1'b0, 1'($urandom_range(0, 1)), $urandom, e, {name, ":HALTED"});
      return;
    end
    if (kind >= 2) return;

    if (kind == 0) begin
      e = '0; e.run = 1'b1; e.gpr_out = rc; e.alu_op = alu; e.z_in = 1'b1;
      cyc(rst_t4, 1'($urandom_range(0, 1)), iv, e, {name, ":T4"});
      if (rst_t4) begin
        e = '0; e.run = 1'b1;
        cyc(1'b0, 1'b0, iv, e, {name, ":rst_mid"});
        return;
      end
    end

    e = '0; e.run = 1'b1; e.z_low_out = 1'b1; e.gpr_in = ra; e.alu_op = alu;
    cyc(1'b0, 1'($urandom_range(0, 1)), iv, e, {name, ":T5"});
  endtask

  logic [4:0] defined_ops [11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                                   5'b01001, 5'b01010, 5'b10000, 5'b10001, 5'b11010};

  initial begin
    logic [31:0] iv;
    logic [4:0]  op;
    obs_t        e;
    reset = 1'b1; start = 1'b0; reset2 = 1'b1; start2 = 1'b0;
    bus.mem_ready = 1'b0; bus.ir = '0; bus2.mem_ready = 1'b0; bus2.ir = '0;

    do_reset("init");
    exec_instr(32'h4A920000, 0, 1'b0, "and");
    exec_instr(32'h4A920000, 3, 1'b0, "memwait");
    exec_instr(32'h89B80000, 0, 1'b0, "not");
    exec_instr(32'hD0000000, 1, 1'b0, "nop");
    exec_instr(32'hF8000000, 0, 1'b0, "undef");
    iv = {5'b00011, 27'($urandom)};
    exec_instr(iv, FT - 1, 1'b0, "lat_edge");
    iv = {5'b00100, 27'($urandom)};
    exec_instr(iv, 0, 1'b1, "rst_t4");
    exec_instr(32'h4A920000, FT, 1'b0, "timeout");
    do_reset("post_fault");
    exec_instr(32'hD8000000, 0, 1'b0, "halt");
    do_reset("post_halt");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) op = defined_ops[$urandom_range(0, 10)];
      else begin
        op = 5'($urandom);
        if (op == 5'b11011) op = 5'b11111;
      end
      iv = {op, 27'($urandom)};
      exec_instr(iv, $urandom_range(0, 4), 1'($urandom_range(0, 7) == 0), "rand");
    end

    // start gating on the START_ON_RESET=0 instance
    @(posedge clk); #1 reset2 = 1'b1;
    @(posedge clk); #1 reset2 = 1'b0;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle", 64'(obs2()), 64'(e));
    end
    @(posedge clk); #1 start2 = 1'b1;
    @(negedge clk);
    chk("idle_start", 64'(obs2()), 64'(e));
    @(negedge clk);
    e.run = 1'b1; e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
    e.alu_op = 4'b0010;
    chk("start_T0", 64'(obs2()), 64'(e));
    @(negedge clk);
    e = '0; e.run = 1'b1; e.read = 1'b1; e.mdr_in = 1'b1; e.pc_in = 1'b1; e.z_low_out = 1'b1;
    chk("start_T1", 64'(obs2()), 64'(e));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
